// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, ID width
// and the per-source gateway state encoding.
package irq_ctrl_pkg;

  localparam int ID_W = 5;

  localparam logic [7:0] ADDR_PENDING   = 8'h00;
  localparam logic [7:0] ADDR_ENABLE    = 8'h01;
  localparam logic [7:0] ADDR_THRESHOLD = 8'h02;
  localparam logic [7:0] ADDR_CLAIM     = 8'h03;
  localparam logic [7:0] ADDR_PRIO_BASE = 8'h10;

  typedef enum logic [1:0] {
    GW_IDLE       = 2'd0,
    GW_PENDING    = 2'd1,
    GW_IN_SERVICE = 2'd2
  } gw_state_e;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: turns a level or rising edge into a single pending
// request and holds it off until firmware completes the service.
module irq_gateway import irq_ctrl_pkg::*; #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  gw_state_e state, state_nxt;
  logic      prev_irq;
  logic      trigger;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GW_IDLE;
      prev_irq <= 1'b0;
    end else begin
      state    <= state_nxt;
      prev_irq <= irq;
    end
  end

  // Triggers seen outside IDLE are dropped, which also resolves claim-vs-edge.
  always_comb begin
    state_nxt = state;
    trigger   = EDGE ? (irq & ~prev_irq) : irq;
    case (state)
      GW_IDLE:       if (trigger)  state_nxt = GW_PENDING;
      GW_PENDING:    if (claim)    state_nxt = GW_IN_SERVICE;
      GW_IN_SERVICE: if (complete) state_nxt = GW_IDLE;
      default:                     state_nxt = GW_IDLE;
    endcase
  end

  assign pending = (state == GW_PENDING);

endmodule

// File: rtl/irq_ctrl.sv
// Machine-level interrupt controller: NUM_SRC gated sources, priority
// arbitration against a threshold, claim/complete through a register port.
module irq_ctrl import irq_ctrl_pkg::*; #(
  parameter int                 NUM_SRC   = 8,
  parameter int                 PRIO_W    = 3,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] i_irq,
  input  logic               i_wr_en,
  input  logic               i_rd_en,
  input  logic [7:0]         i_addr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_rvalid,
  output logic               o_external_interrupt,
  output logic [ID_W-1:0]    o_irq_id
);

  logic [NUM_SRC:1]  pending, enable, claim, complete;
  logic [PRIO_W-1:0] prio [1:NUM_SRC];
  logic [PRIO_W-1:0] threshold;
  logic              rd_go;
  logic [ID_W-1:0]   win_id_p0;
  logic [PRIO_W-1:0] win_prio_p0;
  logic [31:0]       rd_val_p0;

  assign rd_go = i_rd_en & ~i_wr_en;

  always_comb begin
    claim    = '0;
    complete = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      claim[k]    = rd_go && (i_addr == ADDR_CLAIM) && (o_irq_id == ID_W'(k));
      complete[k] = i_wr_en && (i_addr == ADDR_CLAIM) && (i_wdata == 32'(k));
    end
  end

  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_gw
    irq_gateway #(.EDGE(EDGE_MASK[g-1])) u_gw (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .irq      (i_irq[g-1]),
      .claim    (claim[g]),
      .complete (complete[g]),
      .pending  (pending[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      enable    <= '0;
      threshold <= '0;
      for (int k = 1; k <= NUM_SRC; k++) prio[k] <= '0;
    end else if (i_wr_en) begin
      if (i_addr == ADDR_ENABLE)    enable    <= i_wdata[NUM_SRC:1];
      if (i_addr == ADDR_THRESHOLD) threshold <= i_wdata[PRIO_W-1:0];
      for (int k = 1; k <= NUM_SRC; k++)
        if (i_addr == ADDR_PRIO_BASE + 8'(k)) prio[k] <= i_wdata[PRIO_W-1:0];
    end
  end

  // Stage p0: arbitration. A source being claimed this cycle is excluded so
  // a back-to-back claim sees the next winner instead of the same ID again.
  // Strict '>' keeps the lowest ID on priority ties.
  always_comb begin
    win_id_p0   = '0;
    win_prio_p0 = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (pending[k] && enable[k] && !claim[k] && (prio[k] > threshold) &&
          (prio[k] > win_prio_p0)) begin
        win_id_p0   = ID_W'(k);
        win_prio_p0 = prio[k];
      end
    end
  end

  always_comb begin
    rd_val_p0 = '0;
    case (i_addr)
      ADDR_PENDING:   rd_val_p0[NUM_SRC:1]  = pending;
      ADDR_ENABLE:    rd_val_p0[NUM_SRC:1]  = enable;
      ADDR_THRESHOLD: rd_val_p0[PRIO_W-1:0] = threshold;
      ADDR_CLAIM:     rd_val_p0[ID_W-1:0]   = o_irq_id;
      default: begin
        for (int k = 1; k <= NUM_SRC; k++)
          if (i_addr == ADDR_PRIO_BASE + 8'(k)) rd_val_p0[PRIO_W-1:0] = prio[k];
      end
    endcase
  end

  // Stage p1: registered request and read response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_irq_id             <= '0;
      o_external_interrupt <= 1'b0;
      o_rvalid             <= 1'b0;
      o_rdata              <= '0;
    end else begin
      o_irq_id             <= win_id_p0;
      o_external_interrupt <= (win_id_p0 != '0);
      o_rvalid             <= rd_go;
      o_rdata              <= rd_go ? rd_val_p0 : '0;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with 8 sources; source 1 is edge-triggered.
module tb_irq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_irq;
  logic        i_wr_en, i_rd_en;
  logic [7:0]  i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_rvalid, o_external_interrupt;
  logic [4:0]  o_irq_id;

  int n_chk  = 0;
  int n_fail = 0;

  irq_ctrl #(.NUM_SRC(8), .PRIO_W(3), .EDGE_MASK(8'b0000_0001)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_irq(i_irq), .i_wr_en(i_wr_en),
    .i_rd_en(i_rd_en), .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_rvalid(o_rvalid), .o_external_interrupt(o_external_interrupt),
    .o_irq_id(o_irq_id)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk); #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    i_wr_en = 1'b1; i_addr = a; i_wdata = d;
    cyc();
    i_wr_en = 1'b0; i_wdata = '0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic v);
    i_rd_en = 1'b1; i_addr = a;
    cyc();
    d = o_rdata; v = o_rvalid;
    i_rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0; i_irq = '0; i_wr_en = 1'b0; i_rd_en = 1'b0;
    i_addr = '0; i_wdata = '0;
    cyc(); cyc();
    i_rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    apply_reset();
    if ({o_irq_id, o_external_interrupt, o_rvalid, o_rdata} !== '0) begin n_fail++; $display("FAIL reset_outputs: got id=%0d ext=%0b rv=%0b rd=%0h expected all 0", o_irq_id, o_external_interrupt, o_rvalid, o_rdata); end n_chk++;
    for (int a = 0; a < 4; a++) begin
      do_read(8'(a), d, v);
      if (v !== 1'b1) begin n_fail++; $display("FAIL reset_rvalid[%0d]: got %0b expected 1", a, v); end n_chk++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %0h expected 0", a, d); end n_chk++;
    end
    cyc();
    if (o_rvalid !== 1'b0 || o_rdata !== 32'h0) begin n_fail++; $display("FAIL rvalid_pulse: got rv=%0b rd=%0h expected 0/0", o_rvalid, o_rdata); end n_chk++;
  endtask

  task automatic test_level();
    logic [31:0] d; logic v;
    apply_reset();
    do_write(8'h13, 32'd2);
    do_write(8'h01, 32'h08);
    do_write(8'h02, 32'd1);
    i_irq[2] = 1'b1;
    cyc();
    if (o_irq_id !== 5'd0) begin n_fail++; $display("FAIL level_latency: got %0d expected 0", o_irq_id); end n_chk++;
    cyc();
    if (o_irq_id !== 5'd3 || o_external_interrupt !== 1'b1) begin n_fail++; $display("FAIL level_request: got id=%0d ext=%0b expected 3/1", o_irq_id, o_external_interrupt); end n_chk++;
    do_read(8'h03, d, v);
    if (d !== 32'd3 || v !== 1'b1) begin n_fail++; $display("FAIL level_claim: got %0d rv=%0b expected 3/1", d, v); end n_chk++;
    cyc();
    if (o_irq_id !== 5'd0 || o_external_interrupt !== 1'b0) begin n_fail++; $display("FAIL level_drop: got id=%0d ext=%0b expected 0/0", o_irq_id, o_external_interrupt); end n_chk++;
    do_write(8'h03, 32'd3);
    cyc(); cyc();
    if (o_irq_id !== 5'd3 || o_external_interrupt !== 1'b1) begin n_fail++; $display("FAIL level_repend: got id=%0d ext=%0b expected 3/1", o_irq_id, o_external_interrupt); end n_chk++;
  endtask

  task automatic test_arbitration();
    logic [31:0] d; logic v;
    apply_reset();
    do_write(8'h12, 32'd4);
    do_write(8'h15, 32'd4);
    do_write(8'h01, 32'h24);
    i_irq[1] = 1'b1; i_irq[4] = 1'b1;
    cyc(); cyc();
    if (o_irq_id !== 5'd2) begin n_fail++; $display("FAIL arb_tie: got %0d expected 2", o_irq_id); end n_chk++;
    do_read(8'h00, d, v);
    if (d !== 32'h24) begin n_fail++; $display("FAIL arb_pending: got %0h expected 24", d); end n_chk++;
    do_write(8'h15, 32'd6);
    if (o_irq_id !== 5'd2) begin n_fail++; $display("FAIL arb_prio_delay: got %0d expected 2", o_irq_id); end n_chk++;
    cyc();
    if (o_irq_id !== 5'd5) begin n_fail++; $display("FAIL arb_prio_win: got %0d expected 5", o_irq_id); end n_chk++;
    do_write(8'h02, 32'd6);
    cyc();
    if (o_irq_id !== 5'd0 || o_external_interrupt !== 1'b0) begin n_fail++; $display("FAIL arb_threshold: got id=%0d ext=%0b expected 0/0", o_irq_id, o_external_interrupt); end n_chk++;
  endtask

  task automatic test_edge();
    logic [31:0] d; logic v;
    apply_reset();
    do_write(8'h11, 32'd1);
    do_write(8'h01, 32'h02);
    i_irq[0] = 1'b1; cyc(); i_irq[0] = 1'b0; cyc();
    if (o_irq_id !== 5'd1) begin n_fail++; $display("FAIL edge_request: got %0d expected 1", o_irq_id); end n_chk++;
    do_read(8'h03, d, v);
    if (d !== 32'd1) begin n_fail++; $display("FAIL edge_claim: got %0d expected 1", d); end n_chk++;
    i_irq[0] = 1'b1; cyc(); i_irq[0] = 1'b0; cyc();
    do_write(8'h03, 32'd1);
    cyc();
    do_read(8'h00, d, v);
    if (d !== 32'h0 || o_irq_id !== 5'd0) begin n_fail++; $display("FAIL edge_lost: got pend=%0h id=%0d expected 0/0", d, o_irq_id); end n_chk++;
    i_irq[0] = 1'b1; cyc(); i_irq[0] = 1'b0; cyc();
    if (o_irq_id !== 5'd1) begin n_fail++; $display("FAIL edge_repulse: got %0d expected 1", o_irq_id); end n_chk++;
    do_read(8'h00, d, v);
    if (d !== 32'h02) begin n_fail++; $display("FAIL edge_pending: got %0h expected 2", d); end n_chk++;
  endtask

  task automatic test_misc();
    logic [31:0] d; logic v;
    apply_reset();
    do_write(8'h14, 32'd3);
    do_write(8'h01, 32'h10);
    i_irq[3] = 1'b1;
    cyc(); cyc();
    do_read(8'h03, d, v);
    if (d !== 32'd4) begin n_fail++; $display("FAIL misc_claim4: got %0d expected 4", d); end n_chk++;
    do_write(8'h03, 32'd7);
    do_write(8'h03, 32'd0);
    cyc(); cyc();
    if (o_irq_id !== 5'd0) begin n_fail++; $display("FAIL misc_bad_complete: got %0d expected 0", o_irq_id); end n_chk++;
    do_write(8'h03, 32'd4);
    cyc(); cyc();
    if (o_irq_id !== 5'd4) begin n_fail++; $display("FAIL misc_good_complete: got %0d expected 4", o_irq_id); end n_chk++;
    do_read(8'h03, d, v);
    do_read(8'h03, d, v);
    if (d !== 32'd0 || v !== 1'b1) begin n_fail++; $display("FAIL misc_empty_claim: got %0d rv=%0b expected 0/1", d, v); end n_chk++;
    i_irq[3] = 1'b0;
    i_wr_en = 1'b1; i_rd_en = 1'b1; i_addr = 8'h01; i_wdata = 32'h31;
    cyc();
    i_wr_en = 1'b0; i_rd_en = 1'b0;
    if (o_rvalid !== 1'b0) begin n_fail++; $display("FAIL misc_wr_rd_rvalid: got %0b expected 0", o_rvalid); end n_chk++;
    do_read(8'h01, d, v);
    if (d !== 32'h30) begin n_fail++; $display("FAIL misc_wr_rd_enable: got %0h expected 30", d); end n_chk++;
    do_write(8'h02, 32'hFF);
    do_read(8'h02, d, v);
    if (d !== 32'd7) begin n_fail++; $display("FAIL misc_threshold_mask: got %0h expected 7", d); end n_chk++;
    do_write(8'h20, 32'hFFFF_FFFF);
    do_read(8'h20, d, v);
    if (d !== 32'h0 || v !== 1'b1) begin n_fail++; $display("FAIL misc_unmapped: got %0h rv=%0b expected 0/1", d, v); end n_chk++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic v;
    apply_reset();
    do_write(8'h12, 32'd5);
    do_write(8'h16, 32'd3);
    do_write(8'h01, 32'h44);
    i_irq[1] = 1'b1; i_irq[5] = 1'b1;
    cyc(); cyc();
    i_rd_en = 1'b1; i_addr = 8'h03;
    cyc();
    if (o_rdata !== 32'd2) begin n_fail++; $display("FAIL b2b_first: got %0d expected 2", o_rdata); end n_chk++;
    cyc();
    i_rd_en = 1'b0;
    if (o_rdata !== 32'd6 || o_rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %0d rv=%0b expected 6/1", o_rdata, o_rvalid); end n_chk++;
    cyc();
    if (o_irq_id !== 5'd0 || o_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_after: got id=%0d rv=%0b expected 0/0", o_irq_id, o_rvalid); end n_chk++;
  endtask

  task automatic test_async_reset();
    logic [31:0] d; logic v;
    apply_reset();
    do_write(8'h14, 32'd3);
    do_write(8'h01, 32'h10);
    i_irq[3] = 1'b1;
    cyc(); cyc();
    do_read(8'h03, d, v);
    if (d !== 32'd4 || o_rvalid !== 1'b1) begin n_fail++; $display("FAIL ares_claim: got %0d rv=%0b expected 4/1", d, o_rvalid); end n_chk++;
    #2 i_rst_n = 1'b0;
    #1;
    if ({o_irq_id, o_external_interrupt, o_rvalid, o_rdata} !== '0) begin n_fail++; $display("FAIL ares_immediate: got id=%0d ext=%0b rv=%0b rd=%0h expected all 0", o_irq_id, o_external_interrupt, o_rvalid, o_rdata); end n_chk++;
    cyc();
    i_rst_n = 1'b1;
    cyc();
    do_read(8'h00, d, v);
    if (d !== 32'h10) begin n_fail++; $display("FAIL ares_pending: got %0h expected 10", d); end n_chk++;
    do_read(8'h01, d, v);
    if (d !== 32'h0) begin n_fail++; $display("FAIL ares_enable: got %0h expected 0", d); end n_chk++;
    do_read(8'h14, d, v);
    if (d !== 32'h0 || o_irq_id !== 5'd0) begin n_fail++; $display("FAIL ares_prio: got %0h id=%0d expected 0/0", d, o_irq_id); end n_chk++;
    do_write(8'h14, 32'd3);
    do_write(8'h01, 32'h10);
    cyc();
    if (o_irq_id !== 5'd4 || o_external_interrupt !== 1'b1) begin n_fail++; $display("FAIL ares_recover: got id=%0d ext=%0b expected 4/1", o_irq_id, o_external_interrupt); end n_chk++;
  endtask

  initial begin
    i_rst_n = 1'b0; i_irq = '0; i_wr_en = 1'b0; i_rd_en = 1'b0;
    i_addr = '0; i_wdata = '0;
    test_reset();
    test_level();
    test_arbitration();
    test_edge();
    test_misc();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
